// File: rtl/cc_branch_ctrl.sv
// Condition-code and branch sequencer for the SLC-3 datapath.
// Drives NZP load timing, memory wait/timeout, and BR resolution to the PC mux.
module cc_branch_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TW          = 5
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] IR,
  input  logic [2:0]  NZP,
  input  logic        Mem_R,
  output logic        LD_CC,
  output logic        LD_BEN,
  output logic        BEN,
  output logic        LD_PC,
  output logic        Branch_Taken,
  output logic        Busy,
  output logic        Done,
  output logic        Err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT_MEM,
    S_SET_CC,
    S_BEN_EVAL,
    S_BR_RESOLVE,
    S_DONE
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  state_t          state;
  logic [3:0]      op_q;
  logic [2:0]      cond_q;
  logic [TW-1:0]   tcnt;
  logic [1:0]      rd_cnt;
  logic [1:0]      rd_need;

  // Only the opcode and BR condition field are ever consulted.
  logic unused_ir;
  assign unused_ir = ^IR[8:0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= S_IDLE;
      op_q         <= '0;
      cond_q       <= '0;
      tcnt         <= '0;
      rd_cnt       <= '0;
      rd_need      <= '0;
      LD_CC        <= 1'b0;
      LD_BEN       <= 1'b0;
      BEN          <= 1'b0;
      LD_PC        <= 1'b0;
      Branch_Taken <= 1'b0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Err          <= 1'b0;
    end else begin
      LD_CC        <= 1'b0;
      LD_BEN       <= 1'b0;
      LD_PC        <= 1'b0;
      Branch_Taken <= 1'b0;
      Done         <= 1'b0;

      case (state)
        S_IDLE: begin
          if (Start) begin
            op_q   <= IR[15:12];
            cond_q <= IR[11:9];
            Err    <= 1'b0;
            Busy   <= 1'b1;
            state  <= S_DECODE;
          end
        end

        S_DECODE: begin
          tcnt   <= '0;
          rd_cnt <= '0;
          case (op_q)
            OP_ADD, OP_AND, OP_NOT, OP_LEA: begin
              LD_CC <= 1'b1;
              state <= S_SET_CC;
            end
            OP_LD, OP_LDR: begin
              rd_need <= 2'd1;
              state   <= S_WAIT_MEM;
            end
            OP_LDI: begin
              rd_need <= 2'd2;
              state   <= S_WAIT_MEM;
            end
            OP_BR: begin
              // BEN resolves on the edge into BEN_EVAL so the registered
              // value is already valid while LD_BEN is high.
              BEN    <= |(cond_q & NZP);
              LD_BEN <= 1'b1;
              state  <= S_BEN_EVAL;
            end
            default: begin
              Done  <= 1'b1;
              state <= S_DONE;
            end
          endcase
        end

        S_WAIT_MEM: begin
          if (Mem_R) begin
            tcnt   <= '0;
            rd_cnt <= rd_cnt + 2'd1;
            if (rd_cnt + 2'd1 == rd_need) begin
              LD_CC <= 1'b1;
              state <= S_SET_CC;
            end
          end else if (tcnt == TMO_LAST) begin
            Err   <= 1'b1;
            Done  <= 1'b1;
            state <= S_DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        S_SET_CC: begin
          Done  <= 1'b1;
          state <= S_DONE;
        end

        S_BEN_EVAL: begin
          LD_PC        <= BEN;
          Branch_Taken <= BEN;
          state        <= S_BR_RESOLVE;
        end

        S_BR_RESOLVE: begin
          Done  <= 1'b1;
          state <= S_DONE;
        end

        S_DONE: begin
          Busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cc_branch_ctrl.sv
// Self-checking bench for cc_branch_ctrl: vector table feeding an event
// scoreboard, plus hand-written reset / ignored-Start sequences.
module tb_cc_branch_ctrl;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [15:0] IR;
  logic [2:0]  NZP;
  logic        Mem_R;
  logic        LD_CC;
  logic        LD_BEN;
  logic        BEN;
  logic        LD_PC;
  logic        Branch_Taken;
  logic        Busy;
  logic        Done;
  logic        Err;

  cc_branch_ctrl #(.MEM_TIMEOUT(16), .TW(5)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
    .IR           (IR),
    .NZP          (NZP),
    .Mem_R        (Mem_R),
    .LD_CC        (LD_CC),
    .LD_BEN       (LD_BEN),
    .BEN          (BEN),
    .LD_PC        (LD_PC),
    .Branch_Taken (Branch_Taken),
    .Busy         (Busy),
    .Done         (Done),
    .Err          (Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Cycle numbers count the cycle in which Start is driven as cycle 0.
  typedef struct {
    logic [15:0] ir;
    logic [2:0]  nzp;
    int          m1;
    int          m2;
    int          ldcc;
    int          ldben;
    logic        ben;
    int          ldpc;
    int          done;
    logic        err;
  } vec_t;

  // kind: 0 LD_CC, 1 LD_BEN, 2 LD_PC, 3 Branch_Taken, 4 Done
  typedef struct {
    int   kind;
    int   cyc;
    logic val;
  } ev_t;

  ev_t  sbq[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_err = 1'b0;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic monitor(input int n);
    logic [4:0] obs;
    ev_t        e;
    while (sbq.size() > 0 && sbq[0].cyc < n) begin
      e = sbq.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event: kind %0d expected at cycle %0d, not seen by cycle %0d",
               e.kind, e.cyc, n);
    end
    obs = {Done, Branch_Taken, LD_PC, LD_BEN, LD_CC};
    for (int k = 0; k < 5; k++) begin
      if (obs[k]) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: kind %0d at cycle %0d, expected none", k, n);
        end else begin
          e = sbq.pop_front();
          if (e.kind != k || e.cyc != n) begin
            errors++;
            $display("FAIL event_order: saw kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                     k, n, e.kind, e.cyc);
          end else if (k == 1) begin
            check("ben_at_ld_ben", int'(BEN), int'(e.val));
          end else if (k == 4) begin
            check("err_at_done", int'(Err), int'(e.val));
          end
        end
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    if (v.ldcc  >= 0) sbq.push_back('{0, v.ldcc, 1'b0});
    if (v.ldben >= 0) sbq.push_back('{1, v.ldben, v.ben});
    if (v.ldpc  >= 0) begin
      sbq.push_back('{2, v.ldpc, 1'b0});
      sbq.push_back('{3, v.ldpc, 1'b0});
    end
    sbq.push_back('{4, v.done, v.err});

    @(negedge Clk);
    check($sformatf("v%0d_idle_busy", idx), int'(Busy), 0);
    check($sformatf("v%0d_err_hold", idx), int'(Err), int'(prev_err));
    IR    = v.ir;
    NZP   = v.nzp;
    Start = 1'b1;
    Mem_R = 1'b0;
    for (int n = 1; n <= v.done + 1; n++) begin
      @(negedge Clk);
      monitor(n);
      check($sformatf("v%0d_busy_c%0d", idx, n), int'(Busy), (n <= v.done) ? 1 : 0);
      if (n == 1) check($sformatf("v%0d_err_clear", idx), int'(Err), 0);
      if (n == v.done + 1) check($sformatf("v%0d_err_sticky", idx), int'(Err), int'(v.err));
      Start = 1'b0;
      IR    = 16'hFFFF;
      Mem_R = (n == v.m1 || n == v.m2);
    end
    Mem_R    = 1'b0;
    prev_err = v.err;
  endtask

  initial begin
    //           ir        nzp     m1  m2  ldcc ldben ben  ldpc done err
    vecs[0]  = '{16'h1261, 3'b010, -1, -1,  2,  -1, 1'b0, -1,  3, 1'b0}; // ADD
    vecs[1]  = '{16'h0405, 3'b010, -1, -1, -1,   2, 1'b1,  3,  4, 1'b0}; // BRz taken
    vecs[2]  = '{16'h0405, 3'b001, -1, -1, -1,   2, 1'b0, -1,  4, 1'b0}; // BRz not taken
    vecs[3]  = '{16'hA202, 3'b010,  4,  7,  8,  -1, 1'b0, -1,  9, 1'b0}; // LDI
    vecs[4]  = '{16'h2202, 3'b010, -1, -1, -1,  -1, 1'b0, -1, 18, 1'b1}; // LD timeout
    vecs[5]  = '{16'hF025, 3'b010, -1, -1, -1,  -1, 1'b0, -1,  2, 1'b0}; // TRAP, clears Err
    vecs[6]  = '{16'h6042, 3'b100,  3, -1,  4,  -1, 1'b0, -1,  5, 1'b0}; // LDR
    vecs[7]  = '{16'h5A3F, 3'b100, -1, -1,  2,  -1, 1'b0, -1,  3, 1'b0}; // AND
    vecs[8]  = '{16'h96BF, 3'b100, -1, -1,  2,  -1, 1'b0, -1,  3, 1'b0}; // NOT
    vecs[9]  = '{16'hE005, 3'b100, -1, -1,  2,  -1, 1'b0, -1,  3, 1'b0}; // LEA
    vecs[10] = '{16'h2202, 3'b001, 17, -1, 18,  -1, 1'b0, -1, 19, 1'b0}; // LD, last cycle before timeout
    vecs[11] = '{16'hA202, 3'b001,  2, -1, -1,  -1, 1'b0, -1, 19, 1'b1}; // LDI, 2nd read times out
    vecs[12] = '{16'h0000, 3'b111, -1, -1, -1,   2, 1'b0, -1,  4, 1'b0}; // BR cond 000
    vecs[13] = '{16'h0E00, 3'b000, -1, -1, -1,   2, 1'b0, -1,  4, 1'b0}; // BRnzp, NZP 000
    vecs[14] = '{16'h2202, 3'b000,  2, -1,  3,  -1, 1'b0, -1,  4, 1'b0}; // LD, immediate data
    vecs[15] = '{16'hC1C0, 3'b010, -1, -1, -1,  -1, 1'b0, -1,  2, 1'b0}; // JMP, unhandled
    vecs[16] = '{16'h0800, 3'b100, -1, -1, -1,   2, 1'b1,  3,  4, 1'b0}; // BRn taken

    Reset = 1'b1;
    Start = 1'b1;
    IR    = 16'h1261;
    NZP   = 3'b000;
    Mem_R = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_busy",   int'(Busy),         0);
    check("rst_ld_cc",  int'(LD_CC),        0);
    check("rst_ld_ben", int'(LD_BEN),       0);
    check("rst_ben",    int'(BEN),          0);
    check("rst_ld_pc",  int'(LD_PC),        0);
    check("rst_taken",  int'(Branch_Taken), 0);
    check("rst_done",   int'(Done),         0);
    check("rst_err",    int'(Err),          0);
    Reset = 1'b0;
    Start = 1'b0;
    @(negedge Clk);
    check("post_rst_busy", int'(Busy), 0);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Extra Start during an LDR wait is ignored; Reset mid-wait aborts silently.
    @(negedge Clk);
    check("seq_rst_ben_before", int'(BEN), 1);
    IR    = 16'h6042;
    NZP   = 3'b010;
    Start = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      @(negedge Clk);
      check($sformatf("seq_rst_ld_cc_c%0d", n), int'(LD_CC), 0);
      check($sformatf("seq_rst_done_c%0d", n),  int'(Done),  0);
      check($sformatf("seq_rst_busy_c%0d", n),  int'(Busy),  (n <= 6) ? 1 : 0);
      if (n == 6) check("seq_rst_ben_held", int'(BEN), 1);
      if (n >= 7) check($sformatf("seq_rst_ben_c%0d", n), int'(BEN), 0);
      if (n >= 7) check($sformatf("seq_rst_err_c%0d", n), int'(Err), 0);
      Start = (n == 4);
      IR    = (n == 4) ? 16'h1261 : 16'hFFFF;
      Reset = (n == 6);
      Mem_R = (n == 9 || n == 10);
    end
    Mem_R    = 1'b0;
    prev_err = 1'b0;

    // Start held while in DONE must not be accepted.
    @(negedge Clk);
    IR    = 16'h1261;
    NZP   = 3'b010;
    Start = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge Clk);
      if (n == 2) check("seq_done_ld_cc", int'(LD_CC), 1);
      if (n == 3) check("seq_done_pulse", int'(Done), 1);
      if (n >= 4) check($sformatf("seq_done_busy_c%0d", n), int'(Busy), 0);
      if (n >= 4) check($sformatf("seq_done_nodone_c%0d", n), int'(Done), 0);
      Start = (n == 3);
      IR    = (n == 3) ? 16'hF025 : 16'hFFFF;
    end
    Start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
